// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/halfadd.sv
// Single-bit half adder; two instances form the serial full-adder bit cell.
module halfadd (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one operand bit pair per cycle, LSB first, WIDTH cycles per op.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b via inverted b and carry-in 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sub_sel;

    logic             s1, c1, bit_s, c2, bit_c;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    halfadd u_ha_ab (
        .a (a_q[0]),
        .b (b_q[0]),
        .s (s1),
        .c (c1)
    );

    halfadd u_ha_cin (
        .a (s1),
        .b (carry_q),
        .s (bit_s),
        .c (c2)
    );

    assign bit_c = c1 | c2;

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub_sel ? ~b : b;
                    carry_d = sub_sel;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {bit_s, sum_q[WIDTH-1:1]};
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    cout_d  = bit_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to add; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 sub  input  1  subtract select, captured on accepted start (present only with SERIAL_ADD_SUB_EN).
REQ-008 busy  output  1  high while an operation is in progress (SHIFT state).
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 sum  output  WIDTH  result register.
REQ-011 cout  output  1  final carry out (borrow-not when subtracting).

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1: capture a, b (and sub) into shift registers, clear carry register (or set to 1 for subtract), load bit counter 0, go to SHIFT.
REQ-014 IDLE with start=0: hold state; sum and cout keep last values.
REQ-015 SHIFT: each cycle one bit pair (LSB first) SHALL pass through the half-adder datapath with the carry register; sum bit shifted into sum MSB, carry register updated, counter incremented.
REQ-016 SHIFT SHALL last exactly WIDTH cycles; on counter = WIDTH-1 go to DONE.
REQ-017 DONE: done=1 for exactly one cycle, cout = final carry, then return to IDLE.
REQ-018 Latency: start accepted at edge N -> done high in cycle N+WIDTH+1.
REQ-019 start while busy or in DONE SHALL be ignored; no operand capture, no restart.
REQ-020 sum and cout SHALL change only during SHIFT/DONE of an accepted operation; stable otherwise.
REQ-021 Arithmetic: sum = (a + b) mod 2^WIDTH, cout = bit WIDTH of unsigned sum.
REQ-022 Wrap: a = b = all-ones SHALL give sum = all-ones minus 1 (LSB 0), cout = 1.
REQ-023 Counter width SHALL be $clog2(WIDTH)+1; no wrap before transition to DONE.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0.
REQ-025 Reset mid-SHIFT SHALL abort the operation; no done pulse after reset release.
REQ-026 First start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-027 Macro SERIAL_ADD_SUB_EN defined: sub port exists; sub=1 SHALL invert captured b and preset carry to 1, giving sum = (a - b) mod 2^WIDTH, cout = 1 when a >= b.
REQ-028 Macro undefined: no sub port, add only, carry preset 0; timing identical.

Structure
REQ-029 Package serial_add_pkg SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-030 Per-bit datapath SHALL reuse the existing halfadd module, two instances forming the full-adder bit cell (carry = C1 | C2); no other sub-modules.

Verification
REQ-031 WIDTH=8, a=8'h05, b=8'h03, start pulse -> busy 8 cycles, done pulse at cycle 9, sum=8'h08, cout=0.
REQ-032 a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; a=b=8'hFF -> sum=8'hFE, cout=1.
REQ-033 start held high through whole operation and reasserted mid-SHIFT with new operands -> result reflects first operands only; next op starts only after DONE returns to IDLE.
REQ-034 rst_n pulsed low at SHIFT cycle 4 -> outputs zero immediately, no done; new start after release gives correct result.
REQ-035 With SERIAL_ADD_SUB_EN: a=8'h10, b=8'h01, sub=1 -> sum=8'h0F, cout=1; a=8'h01, b=8'h02, sub=1 -> sum=8'hFF, cout=0.
REQ-036 Random back-to-back ops (start in cycle after done) vs reference model, 1000 vectors -> zero mismatches, sum/cout stable between operations.
